dmem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory port.
- Accepts load/store requests over a valid/ready request channel and returns results over a valid/ready response channel.
- Models a word-addressed RAM with a programmable wait-state count, so the processor can be tested against a slow memory.
- Rejects misaligned or out-of-range accesses with an error flag instead of touching storage.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM behind valid/ready request and
// response channels, with a fixed number of wait states per access.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        commit;
  logic        accept;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;

  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic        c_err;
  logic [AW-1:0] c_idx;

  logic [31:0] mem [DEPTH];

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;

  // A zero-wait commit happens on the accept edge itself, so the live request
  // is used there; every later commit uses the latched copy.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state == S_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
    c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH));
    c_idx = c_addr[AW+1:2];
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_n = S_RESP;
            commit  = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= c_err;
        resp_rdata <= (!c_we && !c_err) ? mem[c_idx] : 32'd0;
      end else if (state == S_RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // NOTE: the storage array and request latch carry no reset, which keeps the
  // RAM inferable; the write is gated by reset so an abandoned store never lands.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (reset && commit && c_we && !c_err) mem[c_idx] <= c_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a WAIT_CYCLES=2 instance and a zero-wait
// instance, both checked against an array model of the memory.
module tb_dmem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_z, req_we_z, resp_ready_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic        req_ready_z, resp_valid_z, resp_err_z, busy_z;
  logic [31:0] resp_rdata_z;

  logic [31:0] model   [DEPTH];
  logic [31:0] model_z [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_we(req_we_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z), .resp_rdata(resp_rdata_z),
    .resp_err(resp_err_z), .busy(busy_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_err(input logic [31:0] addr);
    return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
  endfunction

  // One transaction on the waited instance; early raises resp_ready before the
  // response, otherwise resp_ready stays low for hold cycles of backpressure.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit early, input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata;
    exp_err   = is_err(addr);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      if (we) model[addr / 4] = wdata;
      else    exp_rdata = model[addr / 4];
    end
    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    resp_ready = early;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    for (int k = 0; k < W; k++) begin
      check("wait_valid", resp_valid, 0);
      check("wait_busy", busy, 1);
      check("wait_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    check("resp_valid", resp_valid, 1);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_err", resp_err, exp_err);
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("hold_valid", resp_valid, 1);
        check("hold_rdata", resp_rdata, exp_rdata);
        check("hold_err", resp_err, exp_err);
        check("hold_req_ready", req_ready, 0);
        check("hold_busy", busy, 1);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("done_valid", resp_valid, 0);
    check("done_busy", busy, 0);
    check("done_req_ready", req_ready, 1);
    check("done_rdata_kept", resp_rdata, exp_rdata);
    check("done_err_kept", resp_err, exp_err);
    resp_ready = 1'b0;
  endtask

  // Zero-wait instance with req_valid and resp_ready held high: accept, then
  // handshake, on alternating edges.
  task automatic txn_z(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata;
    exp_err   = is_err(addr);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      if (we) model_z[(addr / 4) % 8] = wdata;
      else    exp_rdata = model_z[(addr / 4) % 8];
    end
    req_we_z = we; req_addr_z = addr; req_wdata_z = wdata;
    check("z_req_ready", req_ready_z, 1);
    @(posedge clk); #1;
    check("z_resp_valid", resp_valid_z, 1);
    check("z_resp_rdata", resp_rdata_z, exp_rdata);
    check("z_resp_err", resp_err_z, exp_err);
    check("z_busy", busy_z, 1);
    check("z_req_ready_resp", req_ready_z, 0);
    @(posedge clk); #1;
    check("z_idle_valid", resp_valid_z, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
    else if (r == 7) return {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
    else if (r == 8) return 32'($urandom_range(DEPTH, 4000)) << 2;
    else             return $urandom;
  endfunction

  initial begin
    reset = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    req_valid_z = 0; req_we_z = 0; req_addr_z = 0; req_wdata_z = 0; resp_ready_z = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 1'b1, 0);

    txn(1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 1'b0, 0);
    txn(1'b1, 32'h13, 32'h12345678, 1'b0, 1);
    txn(1'b0, 32'h10, 32'h0, 1'b1, 0);
    txn(1'b0, 32'h100, 32'h0, 1'b0, 0);
    txn(1'b0, 32'hFC, 32'h0, 1'b1, 0);
    txn(1'b0, 32'h10, 32'h0, 1'b0, 5);

    for (int i = 0; i < 60; i++)
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3));

    // Store abandoned by a reset while it is still waiting.
    txn(1'b1, 32'h20, 32'h1, 1'b1, 0);
    txn(1'b0, 32'h20, 32'h0, 1'b1, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_busy", busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_rdata", resp_rdata, 0);
    check("mid_rst_err", resp_err, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h20, 32'h0, 1'b0, 0);

    req_valid_z = 1'b1; resp_ready_z = 1'b1;
    for (int i = 0; i < 8; i++) txn_z(1'b1, 32'(i * 4), $urandom);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = 32'h400;
      txn_z(1'($urandom_range(0, 1)), a, $urandom);
    end
    req_valid_z = 1'b0;
    @(posedge clk); #1;
    check("z_final_busy", busy_z, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
